// File: rtl/api_rx_parser.sv
`default_nettype none
// ============================================================================
// Module      : api_rx_parser
// Description : Reads fixed-length chip blocks from an RX FIFO, validates the
//               marker/type fields and presents the nonce with a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module api_rx_parser #(
    parameter int unsigned BLOCK_LEN = 11,
    parameter int unsigned NONCE_IDX = 2,
    parameter int unsigned MARK_IDX  = 9,
    parameter logic [31:0] MARK      = 32'hbeafbeaf
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_rst,
    input  logic        rx_fifo_empty,
    output logic        rx_fifo_rd_en,
    input  logic [31:0] rx_fifo_dout,
    output logic        nonce_vld,
    input  logic        nonce_rdy,
    output logic [31:0] nonce_dat,
    output logic [15:0] nonce_tag,
    output logic [3:0]  nonce_miner_id,
    output logic [15:0] nonce_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EVAL  = 2'd1,
        PUSH  = 2'd2
    } state_t;

    localparam logic [3:0] c_LEN       = 4'(BLOCK_LEN);
    localparam logic [3:0] c_LAST      = 4'(BLOCK_LEN - 1);
    localparam logic [3:0] c_NONCE_IDX = 4'(NONCE_IDX);
    localparam logic [3:0] c_MARK_IDX  = 4'(MARK_IDX);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_issued;
    logic [3:0]  r_got;
    logic        r_rd_pend;
    logic [31:0] r_w_nonce;
    logic [31:0] r_w_mark;
    logic [31:0] r_w_last;
    logic        r_vld;
    logic [31:0] r_dat;
    logic [15:0] r_tag;
    logic [3:0]  r_miner;
    logic [15:0] r_nonce_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_last_cap;
    logic        w_blk_ok;
    logic        w_accept;

    assign rx_fifo_rd_en = rst_n && (r_state == FETCH) && !rx_fifo_empty
                           && (r_issued < c_LEN);
    assign w_last_cap    = r_rd_pend && (r_got == c_LAST);
    assign w_blk_ok      = (r_w_mark == MARK) && (r_w_last[15:8] == 8'h12);
    assign w_accept      = (r_state == PUSH) && nonce_rdy;

    assign nonce_vld      = r_vld;
    assign nonce_dat      = r_dat;
    assign nonce_tag      = r_tag;
    assign nonce_miner_id = r_miner;
    assign nonce_cnt      = r_nonce_cnt;
    assign drop_cnt       = r_drop_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   if (w_last_cap) w_next = EVAL;
            EVAL:    w_next = w_blk_ok ? PUSH : FETCH;
            PUSH:    if (nonce_rdy) w_next = FETCH;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else if (reg_rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued    <= 4'd0;
            r_got       <= 4'd0;
            r_rd_pend   <= 1'b0;
            r_w_nonce   <= 32'd0;
            r_w_mark    <= 32'd0;
            r_w_last    <= 32'd0;
            r_vld       <= 1'b0;
            r_dat       <= 32'd0;
            r_tag       <= 16'd0;
            r_miner     <= 4'd0;
            r_nonce_cnt <= 16'd0;
            r_drop_cnt  <= 16'd0;
        end else if (reg_rst) begin
            r_issued    <= 4'd0;
            r_got       <= 4'd0;
            r_rd_pend   <= 1'b0;
            r_w_nonce   <= 32'd0;
            r_w_mark    <= 32'd0;
            r_w_last    <= 32'd0;
            r_vld       <= 1'b0;
            r_dat       <= 32'd0;
            r_tag       <= 16'd0;
            r_miner     <= 4'd0;
            r_nonce_cnt <= 16'd0;
            r_drop_cnt  <= 16'd0;
        end else begin
            r_rd_pend <= rx_fifo_rd_en;
            if (rx_fifo_rd_en) begin
                r_issued <= r_issued + 4'd1;
            end
            // FIFO data lags rd_en by one cycle, so capture tracks the pending flag
            if (r_rd_pend) begin
                r_got <= r_got + 4'd1;
                if (r_got == c_NONCE_IDX) r_w_nonce <= rx_fifo_dout;
                if (r_got == c_MARK_IDX)  r_w_mark  <= rx_fifo_dout;
                if (r_got == c_LAST)      r_w_last  <= rx_fifo_dout;
            end
            if (r_state == EVAL) begin
                if (w_blk_ok) begin
                    r_vld   <= 1'b1;
                    r_dat   <= r_w_nonce;
                    r_tag   <= r_w_last[31:16];
                    r_miner <= r_w_last[3:0];
                end else begin
                    if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                    r_issued <= 4'd0;
                    r_got    <= 4'd0;
                end
            end
            if (w_accept) begin
                r_vld    <= 1'b0;
                if (r_nonce_cnt != 16'hFFFF) r_nonce_cnt <= r_nonce_cnt + 16'd1;
                r_issued <= 4'd0;
                r_got    <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/api_rx_parser.md
API_RX_PARSER -- requirements
Module: api_rx_parser

Interface
REQ-001 Parameter BLOCK_LEN, default 11, words per received chip block.
REQ-002 Parameter NONCE_IDX, default 2, word index carrying the nonce.
REQ-003 Parameter MARK_IDX, default 9, word index carrying the marker.
REQ-004 Parameter MARK, default 32'hbeafbeaf, marker value required at MARK_IDX.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 reg_rst  input  1  synchronous soft reset, active high.
REQ-008 rx_fifo_empty  input  1  RX FIFO empty flag.
REQ-009 rx_fifo_rd_en  output  1  RX FIFO read strobe.
REQ-010 rx_fifo_dout  input  32  RX FIFO data, valid the cycle after rd_en.
REQ-011 nonce_vld  output  1  parsed nonce available.
REQ-012 nonce_rdy  input  1  consumer accepts nonce.
REQ-013 nonce_dat  output  32  nonce word (block word NONCE_IDX).
REQ-014 nonce_tag  output  16  block word BLOCK_LEN-1 bits [31:16].
REQ-015 nonce_miner_id  output  4  block word BLOCK_LEN-1 bits [3:0].
REQ-016 nonce_cnt  output  16  count of nonces accepted by consumer.
REQ-017 drop_cnt  output  16  count of blocks discarded as invalid.

Function
REQ-018 States: FETCH, EVAL, PUSH; reset and reg_rst state is FETCH.
REQ-019 rx_fifo_rd_en = (state==FETCH) && !rx_fifo_empty && (issued < BLOCK_LEN), combinational; issued is a 4-bit count of reads issued in the current block.
REQ-020 A read-pending flag is registered from rx_fifo_rd_en; on each cycle it is set, rx_fifo_dout is captured as word index `got` and `got` increments.
REQ-021 Only words NONCE_IDX, MARK_IDX and BLOCK_LEN-1 are stored; the other words are consumed and discarded.
REQ-022 rx_fifo_empty asserted mid-block: reads pause, issued/got hold, and fetching resumes when the FIFO becomes non-empty; there is no timeout.
REQ-023 FETCH -> EVAL in the cycle after the capture with got==BLOCK_LEN-1, i.e. once all BLOCK_LEN words are held.
REQ-024 EVAL lasts exactly 1 cycle; the block is valid iff the marker word == MARK and word BLOCK_LEN-1 bits [15:8] == 8'h12.
REQ-025 EVAL with a valid block -> PUSH; nonce_dat/nonce_tag/nonce_miner_id are loaded and nonce_vld=1 on PUSH entry.
REQ-026 EVAL with an invalid block -> FETCH, drop_cnt increments, and nonce_vld stays 0.
REQ-027 In PUSH, nonce_vld stays 1 and the nonce outputs stay stable until nonce_rdy is sampled high.
REQ-028 PUSH with nonce_rdy=1 -> FETCH next cycle; nonce_vld=0, nonce_cnt increments, and issued/got clear to 0.
REQ-029 issued and got clear to 0 on every entry to FETCH.
REQ-030 nonce_rdy is ignored outside PUSH.
REQ-031 Latency: the last word capture to nonce_vld rising is 2 cycles (capture -> EVAL -> PUSH).
REQ-032 Throughput: with the FIFO never empty and nonce_rdy tied high, one block is processed every BLOCK_LEN+3 cycles.
REQ-033 nonce_cnt and drop_cnt saturate at 16'hFFFF and do not wrap.
REQ-034 Simultaneous reg_rst and any other event: reg_rst wins.

Reset
REQ-035 rst_n low asynchronously forces all of the following: state=FETCH, issued=0, got=0, read-pending=0, nonce_vld=0, nonce_dat=0, nonce_tag=0, nonce_miner_id=0, nonce_cnt=0, drop_cnt=0.
REQ-036 reg_rst high applies the same values as REQ-035 at the next clock edge, with priority over all other logic.
REQ-037 Words of a partial block already read before a reset are lost and are not re-read.
REQ-038 rx_fifo_rd_en is 0 while rst_n is low.

Verification
REQ-039 Scenario: FIFO holds one 11-word block with w2=32'h1234_5678, w9=32'hbeafbeaf, w10=32'hABCD_1203; nonce_rdy=1 -> nonce_vld pulses 1 cycle with nonce_dat=32'h12345678, nonce_tag=16'hABCD, nonce_miner_id=4'd3, nonce_cnt=1.
REQ-040 Scenario: same block with w9=32'h0 -> nonce_vld never asserts, drop_cnt=1, and exactly 11 rd_en pulses occur.
REQ-041 Scenario: valid block with nonce_rdy held low for 20 cycles -> nonce_vld high and outputs constant for 20 cycles, no rd_en pulses, and nonce_cnt increments only after nonce_rdy rises.
REQ-042 Scenario: FIFO empty after 5 words, refilled 30 cycles later -> parser resumes at word 5 and the output equals the contiguous-block result.
REQ-043 Scenario: reg_rst pulsed after 6 words -> all counters and outputs are 0; the next 11 FIFO words parse as a fresh block.
REQ-044 Scenario: drop_cnt preset near saturation by 65540 invalid blocks (or forced) -> drop_cnt holds 16'hFFFF.
